// File: rtl/alarm_unit.sv
// Alarm stage: stores an editable HH:MM alarm and compares it with the running time.
// On a match it rings and drives a square-wave buzzer, with dismiss, snooze and auto-timeout.
module alarm_unit #(
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_SECONDS = 300,
  parameter int unsigned BUZZ_DIV       = 25000,
  parameter int unsigned RST_HOUR       = 7,
  parameter int unsigned RST_MIN        = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic       alarm_en,
  input  logic       up_pulse,
  input  logic       down_pulse,
  input  logic       center_pulse,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic [1:0] edit_field,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer
);

  localparam int unsigned RW = $clog2(RING_SECONDS) + 1;
  localparam int unsigned SW = $clog2(SNOOZE_SECONDS) + 1;
  localparam int unsigned BW = $clog2(BUZZ_DIV);

  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECONDS - 1);
  localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_DIV - 1);

  typedef enum logic [2:0] {IDLE, EDIT_H, EDIT_M, RINGING, SNOOZE} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [4:0]    r_alarm_hour;
  logic [5:0]    r_alarm_min;
  logic          r_match_q;
  logic [RW-1:0] r_ring_cnt;
  logic [SW-1:0] r_snz_cnt;
  logic [BW-1:0] r_buzz_cnt;
  logic          r_tone;
  logic          w_match;
  logic          w_trigger;
  logic          w_ring_entry;
  logic [1:0]    w_edit_field;

  assign w_match = alarm_en && (cur_hour == r_alarm_hour) &&
                   (cur_min == r_alarm_min) && (cur_sec == '0);
  assign w_trigger = w_match && !r_match_q;

  always_comb begin
    w_next_state = r_state;
    w_edit_field = 2'b00;
    case (r_state)
      IDLE: begin
        if (center_pulse)   w_next_state = EDIT_H;
        else if (w_trigger) w_next_state = RINGING;
      end
      EDIT_H: begin
        w_edit_field = 2'b01;
        if (center_pulse) w_next_state = EDIT_M;
      end
      EDIT_M: begin
        w_edit_field = 2'b10;
        if (center_pulse) w_next_state = IDLE;
      end
      RINGING: begin
        if (!alarm_en)                          w_next_state = IDLE;
        else if (center_pulse)                  w_next_state = IDLE;
        else if (up_pulse || down_pulse)        w_next_state = SNOOZE;
        else if (tick_1hz && r_ring_cnt == RING_LAST) w_next_state = IDLE;
      end
      SNOOZE: begin
        if (center_pulse || !alarm_en)               w_next_state = IDLE;
        else if (tick_1hz && r_snz_cnt == SNZ_LAST)  w_next_state = RINGING;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Snooze-to-ring counts as a fresh entry, so counters and tone restart.
  assign w_ring_entry = (w_next_state == RINGING) && (r_state != RINGING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_alarm_hour <= 5'(RST_HOUR);
      r_alarm_min  <= 6'(RST_MIN);
      r_match_q    <= 1'b0;
      r_ring_cnt   <= '0;
      r_snz_cnt    <= '0;
      r_buzz_cnt   <= '0;
      r_tone       <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_match_q <= w_match;

      if (r_state == EDIT_H && (up_pulse ^ down_pulse)) begin
        if (up_pulse) r_alarm_hour <= (r_alarm_hour == 5'd23) ? '0 : r_alarm_hour + 5'd1;
        else          r_alarm_hour <= (r_alarm_hour == '0) ? 5'd23 : r_alarm_hour - 5'd1;
      end
      if (r_state == EDIT_M && (up_pulse ^ down_pulse)) begin
        if (up_pulse) r_alarm_min <= (r_alarm_min == 6'd59) ? '0 : r_alarm_min + 6'd1;
        else          r_alarm_min <= (r_alarm_min == '0) ? 6'd59 : r_alarm_min - 6'd1;
      end

      // Tone is cleared on the same edge that leaves RINGING, keeping buzzer 0 elsewhere.
      if (w_next_state != RINGING || w_ring_entry) begin
        r_buzz_cnt <= '0;
        r_tone     <= 1'b0;
        r_ring_cnt <= '0;
      end else begin
        if (r_buzz_cnt == BUZZ_LAST) begin
          r_buzz_cnt <= '0;
          r_tone     <= ~r_tone;
        end else begin
          r_buzz_cnt <= r_buzz_cnt + BW'(1);
        end
        if (tick_1hz && r_ring_cnt != '1) r_ring_cnt <= r_ring_cnt + RW'(1);
      end

      if (r_state != SNOOZE)                r_snz_cnt <= '0;
      else if (tick_1hz && r_snz_cnt != '1) r_snz_cnt <= r_snz_cnt + SW'(1);
    end
  end

  assign alarm_hour = r_alarm_hour;
  assign alarm_min  = r_alarm_min;
  assign edit_field = w_edit_field;
  assign ringing    = (r_state == RINGING);
  assign snoozing   = (r_state == SNOOZE);
  assign buzzer     = r_tone;

endmodule

// File: tb/tb_alarm_unit.sv
// Directed bench for alarm_unit: editing, trigger, buzzer cadence, timeout, snooze and reset.
module tb_alarm_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic       alarm_en;
  logic       up_pulse;
  logic       down_pulse;
  logic       center_pulse;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [1:0] edit_field;
  logic       ringing;
  logic       snoozing;
  logic       buzzer;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alarm_unit #(
    .RING_SECONDS  (3),
    .SNOOZE_SECONDS(2),
    .BUZZ_DIV      (4),
    .RST_HOUR      (7),
    .RST_MIN       (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_1hz    (tick_1hz),
    .cur_hour    (cur_hour),
    .cur_min     (cur_min),
    .cur_sec     (cur_sec),
    .alarm_en    (alarm_en),
    .up_pulse    (up_pulse),
    .down_pulse  (down_pulse),
    .center_pulse(center_pulse),
    .alarm_hour  (alarm_hour),
    .alarm_min   (alarm_min),
    .edit_field  (edit_field),
    .ringing     (ringing),
    .snoozing    (snoozing),
    .buzzer      (buzzer)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_up();     up_pulse = 1'b1;     cyc(1); up_pulse = 1'b0;     endtask
  task automatic press_down();   down_pulse = 1'b1;   cyc(1); down_pulse = 1'b0;   endtask
  task automatic press_center(); center_pulse = 1'b1; cyc(1); center_pulse = 1'b0; endtask
  task automatic tick();         tick_1hz = 1'b1;     cyc(1); tick_1hz = 1'b0; cyc(1); endtask

  initial begin
    rst_n = 1'b0; tick_1hz = 1'b0; alarm_en = 1'b0;
    up_pulse = 1'b0; down_pulse = 1'b0; center_pulse = 1'b0;
    cur_hour = '0; cur_min = '0; cur_sec = '0;
    cyc(3);
    chk("rst_hour", alarm_hour, 7);
    chk("rst_min", alarm_min, 0);
    chk("rst_edit", edit_field, 0);
    chk("rst_ring", ringing, 0);
    chk("rst_buzz", buzzer, 0);
    rst_n = 1'b1;
    cyc(1);
    chk("post_rst_hour", alarm_hour, 7);

    // Edit hour: 7 -> 10, down wrap 0->23, up wrap 23->0, back to 10
    press_center();
    chk("edit_h_field", edit_field, 1);
    repeat (3) press_up();
    chk("hour_up3", alarm_hour, 10);
    up_pulse = 1'b1; down_pulse = 1'b1; cyc(1); up_pulse = 1'b0; down_pulse = 1'b0;
    chk("hour_updown", alarm_hour, 10);
    repeat (11) press_down();
    chk("hour_wrap_down", alarm_hour, 23);
    press_up();
    chk("hour_wrap_up", alarm_hour, 0);
    repeat (10) press_up();
    chk("hour_back10", alarm_hour, 10);
    press_center();
    chk("edit_m_field", edit_field, 2);
    press_down();
    chk("min_wrap_down", alarm_min, 59);
    press_center();
    chk("edit_done_field", edit_field, 0);
    chk("edit_done_hour", alarm_hour, 10);

    // Trigger at 10:59:00
    alarm_en = 1'b1;
    cur_hour = 5'd10; cur_min = 6'd58; cur_sec = 6'd59;
    cyc(2);
    chk("no_ring_pre", ringing, 0);
    cur_min = 6'd59; cur_sec = 6'd0;
    cyc(1);
    chk("ring_latency", ringing, 1);
    chk("buzz_entry", buzzer, 0);
    cyc(3);
    chk("buzz_low_end", buzzer, 0);
    cyc(1);
    chk("buzz_rise", buzzer, 1);
    cyc(3);
    chk("buzz_high_end", buzzer, 1);
    cyc(1);
    chk("buzz_fall", buzzer, 0);
    press_center();
    chk("dismiss_ring", ringing, 0);
    chk("dismiss_buzz", buzzer, 0);
    cyc(10);
    chk("one_trigger", ringing, 0);

    // Auto-timeout after 3 ticks
    cur_sec = 6'd1; cyc(1); cur_sec = 6'd0; cyc(1);
    chk("retrig_ring", ringing, 1);
    tick(); tick();
    chk("ring_2ticks", ringing, 1);
    tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
    chk("timeout_ring", ringing, 0);
    chk("timeout_buzz", buzzer, 0);

    // Snooze
    cur_sec = 6'd1; cyc(1); cur_sec = 6'd0; cyc(1);
    chk("snz_pre_ring", ringing, 1);
    cyc(4);
    chk("snz_pre_buzz", buzzer, 1);
    press_up();
    chk("snz_state", snoozing, 1);
    chk("snz_ring", ringing, 0);
    chk("snz_buzz", buzzer, 0);
    tick();
    press_down();
    chk("snz_ignore_dn", snoozing, 1);
    tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
    chk("snz_resume_ring", ringing, 1);
    chk("snz_resume_snz", snoozing, 0);
    chk("snz_resume_buzz", buzzer, 0);
    press_up();
    chk("snz_again", snoozing, 1);
    press_center();
    chk("snz_center_snz", snoozing, 0);
    chk("snz_center_ring", ringing, 0);

    // Disabled alarm: no ring on match; disable while ringing stops it
    alarm_en = 1'b0;
    cur_sec = 6'd1; cyc(1); cur_sec = 6'd0; cyc(3);
    chk("dis_no_ring", ringing, 0);
    alarm_en = 1'b1;
    cur_sec = 6'd1; cyc(1); cur_sec = 6'd0; cyc(1);
    chk("en_ring", ringing, 1);
    alarm_en = 1'b0; cyc(1);
    chk("dis_stop_ring", ringing, 0);

    // Async reset mid-ringing
    alarm_en = 1'b1;
    cur_sec = 6'd1; cyc(1); cur_sec = 6'd0; cyc(1);
    cyc(4);
    chk("pre_rst_buzz", buzzer, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ring", ringing, 0);
    chk("arst_buzz", buzzer, 0);
    chk("arst_hour", alarm_hour, 7);
    chk("arst_min", alarm_min, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
